// File: rtl/lane_permute_pkg.sv
// Shared types and constants for the lane permutation sequencer.
// The optional rotation stage is enabled by defining LANE_PERMUTE_ROT_EN.
package lane_permute_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CALC,
    MOD,
    WR,
    NEXT,
    DONE
  } state_t;

  localparam int DEFAULT_DIM = 5;
  localparam int ROT_STEP = 3;

  function automatic int idx_w(input int dim);
    return $clog2(dim * dim);
  endfunction

  // The accumulator has to hold 2x+3y at its largest, which is 5*(DIM-1).
  function automatic int acc_w(input int dim);
    return $clog2(5 * (dim - 1) + 1);
  endfunction

  localparam int ACC_W = acc_w(DEFAULT_DIM);

endpackage

// File: rtl/lane_mod_reducer.sv
// Iterative modulo-DIM reducer: load a value, then subtract DIM once per step
// cycle until the result falls below DIM, at which point ready is raised.
module lane_mod_reducer
  import lane_permute_pkg::*;
#(
  parameter int DIM = DEFAULT_DIM,
  parameter int ACC_BITS = ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [ACC_BITS-1:0] load_val,
  output logic [ACC_BITS-1:0] acc,
  output logic                ready
);

  localparam logic [ACC_BITS-1:0] DIM_A = ACC_BITS'(DIM);

  assign ready = (acc < DIM_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (step && !ready) begin
      acc <= acc - DIM_A;
    end
  end

endmodule

// File: rtl/lane_permute_ctrl.sv
// Lane permutation sequencer: reads every lane (x,y) and writes it to (y, (2x+3y) mod DIM).
// Define LANE_PERMUTE_ROT_EN to rotate each lane left by 3*k mod LANE_W on its way out.
module lane_permute_ctrl
  import lane_permute_pkg::*;
#(
  parameter  int DIM    = 5,
  parameter  int LANE_W = 64,
  localparam int IDX_W  = idx_w(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              ok,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [LANE_W-1:0] rd_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [IDX_W-1:0]  wr_addr,
  output logic [LANE_W-1:0] wr_data
);

  localparam int CRD_W = $clog2(DIM);
  localparam int ACC_BITS = acc_w(DIM);
  localparam logic [CRD_W-1:0] LAST = CRD_W'(DIM - 1);
  localparam logic [IDX_W-1:0] DIM_I = IDX_W'(DIM);

  state_t state, state_nxt;
  logic [CRD_W-1:0] x, y;
  logic [LANE_W-1:0] lane_q, lane_out;
  logic [ACC_BITS-1:0] acc, acc_init;
  logic acc_ready, last_lane;

  assign last_lane = (x == LAST) && (y == LAST);
  assign acc_init = (ACC_BITS'(x) << 1) + ACC_BITS'(y) + (ACC_BITS'(y) << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RD;
      RD:   if (rd_ack) state_nxt = CALC;
      CALC: state_nxt = MOD;
      MOD:  if (acc_ready) state_nxt = WR;
      WR:   if (wr_ack) state_nxt = NEXT;
      NEXT: state_nxt = last_lane ? DONE : RD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Coordinates return to (0,0) after the last lane so they never leave the grid.
  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      lane_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end
      if (state == RD && rd_ack) begin
        lane_q <= rd_data;
      end
      if (state == NEXT) begin
        if (x == LAST) begin
          x <= '0;
          y <= last_lane ? '0 : y + CRD_W'(1);
        end else begin
          x <= x + CRD_W'(1);
        end
      end
    end
  end

  lane_mod_reducer #(
    .DIM      (DIM),
    .ACC_BITS (ACC_BITS)
  ) u_reducer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CALC),
    .step     (state == MOD),
    .load_val (acc_init),
    .acc      (acc),
    .ready    (acc_ready)
  );

`ifdef LANE_PERMUTE_ROT_EN
  localparam int ROT_W = $clog2(LANE_W);
  localparam int RS_W = ROT_W + 1;
  localparam logic [RS_W-1:0] ROT_LIM = RS_W'(LANE_W);

  logic [ROT_W-1:0] rot_off;
  logic [RS_W-1:0] rot_sum;

  assign rot_sum = {1'b0, rot_off} + RS_W'(ROT_STEP);
  assign lane_out = (lane_q << rot_off) | (lane_q >> (ROT_LIM - {1'b0, rot_off}));

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_off <= '0;
    end else if (state == IDLE && start) begin
      rot_off <= '0;
    end else if (state == NEXT) begin
      rot_off <= (rot_sum >= ROT_LIM) ? ROT_W'(rot_sum - ROT_LIM) : ROT_W'(rot_sum);
    end
  end
`else
  assign lane_out = lane_q;
`endif

  // Addresses and data are forced to zero outside their request states.
  assign busy    = (state != IDLE);
  assign ok      = (state == DONE);
  assign rd_req  = (state == RD);
  assign wr_req  = (state == WR);
  assign rd_addr = rd_req ? (IDX_W'(y) * DIM_I + IDX_W'(x)) : '0;
  assign wr_addr = wr_req ? (IDX_W'(acc) * DIM_I + IDX_W'(y)) : '0;
  assign wr_data = wr_req ? lane_out : '0;

endmodule

// File: tb/tb_lane_permute_ctrl.sv
// Randomised scoreboard bench for lane_permute_ctrl; honours LANE_PERMUTE_ROT_EN
// when building the expected write data.
module tb_lane_permute_ctrl;

  localparam int D = 5;
  localparam int W = 64;
  localparam int N = D * D;
  localparam int AW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rd_ack = 1'b0;
  logic wr_ack = 1'b0;
  logic [W-1:0] rd_data = '0;
  logic busy, ok, rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0] wr_data;

  typedef struct {
    int addr;
    logic [W-1:0] data;
  } wr_exp_t;

  int exp_rd[$];
  wr_exp_t exp_wr[$];
  logic [W-1:0] src[N];
  int hits[N];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ok_count = 0;
  int max_delay = 0;
  int rd_idx = 0;
  int prev_cyc = 0;
  bit hold_wr = 1'b0;

  bit rd_trk = 1'b0;
  bit wr_trk = 1'b0;
  bit ok_prev = 1'b0;
  int rd_wait = 0;
  int wr_wait = 0;
  logic [AW-1:0] rd_hold, wr_hold_a;
  logic [W-1:0] wr_hold_d;
  wr_exp_t mon_e;

  lane_permute_ctrl #(
    .DIM    (D),
    .LANE_W (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .ok      (ok),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_req  (wr_req),
    .wr_ack  (wr_ack),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < W; i++) res[(i + r) % W] = v[i];
    return res;
  endfunction

  function automatic int nsub(input int k);
    return (2 * (k % D) + 3 * (k / D)) / D;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder and scoreboard monitor: answers requests with random
  // latency, throws stray acks when idle, and checks every transfer.
  always @(negedge clk) begin
    if (rst) begin
      rd_trk  = 1'b0;
      wr_trk  = 1'b0;
      ok_prev = 1'b0;
      rd_ack  = 1'b0;
      wr_ack  = 1'b0;
    end else begin
      if (ok_prev) check_output("busy_after_ok", {63'd0, busy}, 64'd0);
      ok_prev = ok;
      if (ok) begin
        ok_count++;
        check_output("queues_empty_at_ok", 64'(exp_rd.size() + exp_wr.size()), 64'd0);
      end
      if (rd_req || wr_req) check_output("req_exclusive", {63'd0, rd_req & wr_req}, 64'd0);

      if (rd_req) begin
        if (!rd_trk) begin
          rd_trk  = 1'b1;
          rd_hold = rd_addr;
          rd_wait = $urandom_range(0, max_delay);
          if (exp_rd.size() == 0) check_output("rd_unexpected", 64'd1, 64'd0);
          else check_output("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
          if (max_delay == 0 && rd_idx > 0)
            check_output("lane_latency", 64'(cyc - prev_cyc), 64'(5 + nsub(rd_idx - 1)));
          prev_cyc = cyc;
          rd_idx++;
        end else begin
          check_output("rd_addr_stable", 64'(rd_addr), 64'(rd_hold));
        end
        if (rd_wait == 0) begin
          rd_ack  = 1'b1;
          rd_data = (int'(rd_addr) < N) ? src[rd_addr] : '0;
          rd_trk  = 1'b0;
        end else begin
          rd_wait--;
          rd_ack = 1'b0;
        end
      end else begin
        rd_trk  = 1'b0;
        rd_ack  = ($urandom_range(0, 3) == 0);
        rd_data = {$urandom, $urandom};
      end

      if (wr_req) begin
        if (!wr_trk) begin
          wr_trk    = 1'b1;
          wr_hold_a = wr_addr;
          wr_hold_d = wr_data;
          wr_wait   = $urandom_range(0, max_delay);
          if (int'(wr_addr) < N) hits[wr_addr]++;
          if (exp_wr.size() == 0) begin
            check_output("wr_unexpected", 64'd1, 64'd0);
          end else begin
            mon_e = exp_wr.pop_front();
            check_output("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
            check_output("wr_data", wr_data, mon_e.data);
          end
        end else begin
          check_output("wr_addr_stable", 64'(wr_addr), 64'(wr_hold_a));
          check_output("wr_data_stable", wr_data, wr_hold_d);
        end
        if (hold_wr) begin
          wr_ack = 1'b0;
        end else if (wr_wait == 0) begin
          wr_ack = 1'b1;
          wr_trk = 1'b0;
        end else begin
          wr_wait--;
          wr_ack = 1'b0;
        end
      end else begin
        wr_trk = 1'b0;
        wr_ack = !hold_wr && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Builds the expected reads and writes for one sweep straight from the
  // permutation rule, in y-major / x-minor order.
  task automatic prepare(input bit unit_lanes);
    wr_exp_t e;
    int k;
    exp_rd.delete();
    exp_wr.delete();
    rd_idx = 0;
    for (int i = 0; i < N; i++) hits[i] = 0;
    for (int yy = 0; yy < D; yy++) begin
      for (int xx = 0; xx < D; xx++) begin
        k = yy * D + xx;
        src[k] = unit_lanes ? 64'h1 : {$urandom, $urandom};
        exp_rd.push_back(k);
        e.addr = ((2 * xx + 3 * yy) % D) * D + yy;
`ifdef LANE_PERMUTE_ROT_EN
        e.data = rotl(src[k], (3 * k) % W);
`else
        e.data = src[k];
`endif
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic apply_stimulus(input int delay_max, input bit noisy);
    int base;
    max_delay = delay_max;
    base = ok_count;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4000 && ok_count == base; c++) begin
      @(negedge clk);
      start = noisy && busy && ($urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("single_ok", 64'(ok_count - base), 64'd1);
    check_output("idle_after_sweep", {63'd0, busy}, 64'd0);
    check_output("all_reads_seen", 64'(exp_rd.size()), 64'd0);
    check_output("all_writes_seen", 64'(exp_wr.size()), 64'd0);
    for (int i = 0; i < N; i++) check_output($sformatf("dest_hit_%0d", i), 64'(hits[i]), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_output({tag, "_ok"}, {63'd0, ok}, 64'd0);
    check_output({tag, "_rd_req"}, {63'd0, rd_req}, 64'd0);
    check_output({tag, "_wr_req"}, {63'd0, wr_req}, 64'd0);
    check_output({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check_output({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check_output({tag, "_wr_data"}, wr_data, 64'd0);
  endtask

  // Holds off the write ack so the sweep parks in its first write, then
  // resets in the middle of it.
  task automatic reset_mid_write();
    bit seen;
    prepare(1'b0);
    max_delay = 0;
    hold_wr = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = wr_req;
    end
    check_output("reached_wr", {63'd0, seen}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_wr_reset");
    rst = 1'b0;
    hold_wr = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] lane_permute_ctrl bench, DIM=%0d LANE_W=%0d", D, W);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    prepare(1'b0);
    apply_stimulus(0, 1'b0);
    prepare(1'b0);
    apply_stimulus(3, 1'b0);
    prepare(1'b0);
    apply_stimulus(2, 1'b1);
    prepare(1'b1);
    apply_stimulus(0, 1'b1);
    reset_mid_write();
    prepare(1'b0);
    apply_stimulus(1, 1'b0);
    prepare(1'b0);
    apply_stimulus(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
